// File: rtl/restoring_divider_if.sv
// Operand/result bundle for the restoring divider.
// Handshake: start is a request sampled on the rising edge while the divider is idle or
// finished, and A/B are taken on that edge. done is a one-cycle pulse, and Q/R/DIV0 are
// valid from that cycle until the next result.
interface restoring_divider_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             DIV0;
  logic [1:0]       dbg_state;

  modport master (
    output start, A, B,
    input  busy, done, Q, R, DIV0, dbg_state
  );

  modport slave (
    input  start, A, B,
    output busy, done, Q, R, DIV0, dbg_state
  );
endinterface

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one shift/trial-subtract/restore step per clock,
// WIDTH steps per operation, with results held in registers until the next completion.
module restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  restoring_divider_if.slave  bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             div0_q, div0_d;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;
  logic             borrow;
  logic [WIDTH:0]   rem_nx;
  logic             qbit;

  // Trial subtraction with an explicit borrow bit; rem stays below the divisor, so the
  // bit shifted out of rem's MSB is always zero.
  always_comb begin
    rem_sh = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    trial  = {1'b0, rem_sh} - {2'b00, dvs_q};
    borrow = trial[WIDTH+1];
    rem_nx = borrow ? rem_sh : trial[WIDTH:0];
    qbit   = ~borrow;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    q_d     = q_q;
    r_d     = r_q;
    div0_d  = div0_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          dvd_d = bus.A;
          dvs_d = bus.B;
          rem_d = '0;
          cnt_d = '0;
          if (bus.B == '0) begin
            q_d     = '1;
            r_d     = bus.A;
            div0_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        rem_d = rem_nx;
        dvd_d = {dvd_q[WIDTH-2:0], qbit};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          q_d     = {dvd_q[WIDTH-2:0], qbit};
          r_d     = rem_nx[WIDTH-1:0];
          div0_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      r_q     <= r_d;
      div0_q  <= div0_d;
    end
  end

  assign bus.busy      = (state_q == S_RUN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.Q         = q_q;
  assign bus.R         = r_q;
  assign bus.DIV0      = div0_q;
  assign bus.dbg_state = state_q;

endmodule
